// File: rtl/eth_link_pkg.sv
// eth_link_pkg: shared state encoding and helpers for the Ethernet link bring-up supervisor.
package eth_link_pkg;

    typedef enum logic [2:0] {
        RESET_PHY = 3'd0,
        WAIT_TX   = 3'd1,
        WAIT_RX   = 3'd2,
        WAIT_BLK  = 3'd3,
        LINK_UP   = 3'd4,
        FAULT     = 3'd5
    } link_state_e;

    // Successor along the normal bring-up path; LINK_UP falls back to RESET_PHY on loss.
    function automatic link_state_e advance(input link_state_e s);
        return (s == RESET_PHY) ? WAIT_TX :
               (s == WAIT_TX)   ? WAIT_RX :
               (s == WAIT_RX)   ? WAIT_BLK :
               (s == WAIT_BLK)  ? LINK_UP : RESET_PHY;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// bit_sync: two-flop synchroniser for a single asynchronous level input.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
endmodule

// File: rtl/eth_link_bringup.sv
// eth_link_bringup: multi-lane PHY bring-up and supervision FSM with bounded retries,
// loss qualification and per-lane failure reporting.
module eth_link_bringup
    import eth_link_pkg::*;
#(
    parameter int LANES         = 4,
    parameter int RESET_CYCLES  = 64,
    parameter int TIMEOUT       = 2**20,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOSS_CYCLES   = 8,
    parameter int MAX_RETRIES   = 7
) (
    input  logic                             core_clk,
    input  logic                             core_reset,
    input  logic                             pll_locked,
    input  logic [LANES-1:0]                 tx_ready,
    input  logic [LANES-1:0]                 rx_ready,
    input  logic [LANES-1:0]                 rx_is_lockedtodata,
    input  logic [LANES-1:0]                 rx_blk_lock,
    input  logic                             loopback_req,
    output logic                             phy_reset_req,
    output logic [LANES-1:0]                 loopback_en,
    output logic                             link_up,
    output logic                             fault,
    output logic [2:0]                       state,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
    output logic [LANES-1:0]                 lane_fail_mask,
    output logic [15:0]                      link_drop_count
);
    localparam int TW = $clog2((TIMEOUT > RESET_CYCLES ? TIMEOUT : RESET_CYCLES) + 1);
    localparam int QW = $clog2((STABLE_CYCLES > LOSS_CYCLES ? STABLE_CYCLES : LOSS_CYCLES) + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    link_state_e      state_q, state_d;
    logic [TW-1:0]    t_q, t_d, t_inc;
    logic [QW-1:0]    q_q, q_d, q_inc;
    logic [RW-1:0]    retry_q, retry_d;
    logic [LANES-1:0] mask_q, mask_d, unmet, lane_ok, rx_ok;
    logic [15:0]      drop_q, drop_d;
    logic             lb_q, lb_d, lb_s, exit_ok, timed_out;

    bit_sync u_lb_sync (
        .clk (core_clk),
        .rst (core_reset),
        .d   (loopback_req),
        .q   (lb_s)
    );

    always_comb begin
        lane_ok   = rx_blk_lock & rx_is_lockedtodata;
        rx_ok     = rx_is_lockedtodata & rx_ready;
        t_inc     = (t_q == '1) ? t_q : t_q + 1'b1;
        q_inc     = (q_q == '1) ? q_q : q_q + 1'b1;
        state_d   = state_q;
        q_d       = q_q;
        retry_d   = retry_q;
        mask_d    = mask_q;
        drop_d    = drop_q;
        lb_d      = lb_q;
        exit_ok   = 1'b0;
        unmet     = '0;
        case (state_q)
            RESET_PHY: exit_ok = (t_q == TW'(RESET_CYCLES - 1));
            WAIT_TX: begin
                exit_ok = pll_locked & (&tx_ready);
                unmet   = {LANES{~pll_locked}} | ~tx_ready;
            end
            WAIT_RX: begin
                exit_ok = &rx_ok;
                unmet   = ~rx_ok;
            end
            WAIT_BLK: begin
                exit_ok = (&rx_blk_lock) && (q_q == QW'(STABLE_CYCLES - 1));
                unmet   = ~rx_blk_lock;
                q_d     = (&rx_blk_lock) ? q_inc : '0;
            end
            LINK_UP: begin
                exit_ok = (~&lane_ok) && (q_q == QW'(LOSS_CYCLES - 1));
                unmet   = ~lane_ok;
                q_d     = (~&lane_ok) ? q_inc : '0;
            end
            default: ;
        endcase
        timed_out = (state_q inside {WAIT_TX, WAIT_RX, WAIT_BLK}) && (t_q == TW'(TIMEOUT - 1));
        if (exit_ok) begin
            state_d = advance(state_q);
            if (state_q == LINK_UP) begin
                mask_d = unmet;
                drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
            end
        end else if (timed_out) begin
            mask_d  = unmet;
            retry_d = retry_q + 1'b1;
            state_d = (retry_q == RW'(MAX_RETRIES - 1)) ? FAULT : RESET_PHY;
        end
        if (state_d == LINK_UP) retry_d = '0;
        // A loopback change restarts bring-up from anywhere, including FAULT.
        if (state_q != RESET_PHY && lb_s != lb_q) begin
            state_d = RESET_PHY;
            retry_d = '0;
            mask_d  = mask_q;
            drop_d  = drop_q;
        end
        if (state_d == RESET_PHY && state_q != RESET_PHY) lb_d = lb_s;
        t_d = (state_d != state_q) ? '0 : t_inc;
        if (state_d != state_q) q_d = '0;
    end

    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            state_q <= RESET_PHY;
            t_q     <= '0;
            q_q     <= '0;
            retry_q <= '0;
            mask_q  <= '0;
            drop_q  <= '0;
            lb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            q_q     <= q_d;
            retry_q <= retry_d;
            mask_q  <= mask_d;
            drop_q  <= drop_d;
            lb_q    <= lb_d;
        end
    end

    assign phy_reset_req   = (state_q == RESET_PHY);
    assign link_up         = (state_q == LINK_UP);
    assign fault           = (state_q == FAULT);
    assign state           = state_q;
    assign loopback_en     = {LANES{lb_q}};
    assign retry_count     = retry_q;
    assign lane_fail_mask  = mask_q;
    assign link_drop_count = drop_q;
endmodule
